// File: rtl/trng_health_fifo.sv
`timescale 1ns/1ps
// trng_health_fifo: TRNG consumer running RCT/APT health tests, startup discard and a first-word-fall-through buffer.
// Latency: trng_ready seen in REQ at cycle T -> CHECK at T+1 -> pushed word or alarm visible at T+2.
// Backpressure: no TRNG request while the buffer is full; an alarm flushes the buffer and halts until fail_clear.
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset (wins over everything)
//   trng_request/ready/data   one-word-at-a-time handshake with the TRNG word generator
//   rnd_valid/ready/data      valid/ready output port, head of the word buffer
//   health_fail, fail_code    sticky alarm; fail_code[0] = RCT, fail_code[1] = APT
//   startup_done              high once STARTUP_WORDS healthy words have been discarded
//   fail_clear                one-cycle pulse, honoured only while alarmed
module trng_health_fifo #(
  parameter int DEPTH         = 4,
  parameter int STARTUP_WORDS = 4,
  parameter int RCT_CUTOFF    = 3,
  parameter int APT_WINDOW    = 64,
  parameter int APT_LO        = 924,
  parameter int APT_HI        = 1124
) (
  input  logic        clk,
  input  logic        rst,
  output logic        trng_request,
  input  logic        trng_ready,
  input  logic [31:0] trng_data,
  output logic        rnd_valid,
  input  logic        rnd_ready,
  output logic [31:0] rnd_data,
  output logic        health_fail,
  output logic [1:0]  fail_code,
  output logic        startup_done,
  input  logic        fail_clear
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_DROP  = 3'd3;
  localparam logic [2:0] ST_FAIL  = 3'd4;

  logic [2:0]    state;
  logic [31:0]   sample;
  logic [31:0]   prev;
  logic          prev_valid;
  logic [3:0]    run;
  logic [11:0]   sum;
  logic [6:0]    win;
  logic [7:0]    start_cnt;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          in_check;
  logic [3:0]    run_next;
  logic          rct_fail;
  logic [11:0]   sum_next;
  logic [6:0]    win_next;
  logic          win_full;
  logic          apt_fail;
  logic          chk_fail;
  logic          push;
  logic          pop;
  logic          flush;

  function automatic logic [5:0] popcount32(input logic [31:0] w);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, w[i]};
    end
    return c;
  endfunction

  // Health test datapath, evaluated on the latched sample during CHECK.
  assign in_check = (state == ST_CHECK);
  assign run_next = (prev_valid && (sample == prev)) ? run + 4'd1 : 4'd1;
  assign rct_fail = (run_next >= 4'(RCT_CUTOFF));
  assign sum_next = sum + {6'd0, popcount32(sample)};
  assign win_next = win + 7'd1;
  assign win_full = (win_next == 7'(APT_WINDOW));
  // The window verdict includes the word that completes the window.
  assign apt_fail = win_full && ((sum_next < 12'(APT_LO)) || (sum_next > 12'(APT_HI)));
  assign chk_fail = rct_fail || apt_fail;

  assign startup_done = (start_cnt == 8'(STARTUP_WORDS));
  assign trng_request = (state == ST_REQ);

  // Healthy words are only buffered once startup has completed.
  assign push  = in_check && !chk_fail && startup_done;
  assign flush = in_check && chk_fail;

  // Valid is masked in FAIL so rnd_ready is ignored there; the buffer is empty by then anyway.
  assign rnd_valid = (count != '0) && (state != ST_FAIL);
  assign rnd_data  = rnd_valid ? mem[rd_ptr] : '0;
  assign pop       = rnd_valid && rnd_ready;

  // Word storage carries no reset; rnd_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sample;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      sample      <= '0;
      prev        <= '0;
      prev_valid  <= 1'b0;
      run         <= '0;
      sum         <= '0;
      win         <= '0;
      start_cnt   <= '0;
      health_fail <= 1'b0;
      fail_code   <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          // Counting the pop lets a request go out the cycle after a slot frees up.
          if (((count < CW'(DEPTH)) || pop) && !health_fail) begin
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (trng_ready) begin
            sample <= trng_data;
            state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          run        <= run_next;
          prev       <= sample;
          prev_valid <= 1'b1;
          if (win_full) begin
            sum <= '0;
            win <= '0;
          end else begin
            sum <= sum_next;
            win <= win_next;
          end
          if (chk_fail) begin
            health_fail <= 1'b1;
            fail_code   <= {apt_fail, rct_fail};
            state       <= ST_FAIL;
          end else begin
            if (!startup_done) begin
              start_cnt <= start_cnt + 8'd1;
            end
            state <= ST_DROP;
          end
        end
        ST_DROP: begin
          // Wait for the TRNG to drop ready so every word is a fresh collection.
          if (!trng_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_FAIL: begin
          if (fail_clear) begin
            health_fail <= 1'b0;
            fail_code   <= 2'b00;
            run         <= '0;
            prev_valid  <= 1'b0;
            sum         <= '0;
            win         <= '0;
            start_cnt   <= '0;
            state       <= ST_DROP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trng_health_fifo.sv
`timescale 1ns/1ps
// tb_trng_health_fifo: directed sequence with a random TRNG source, checked against a word-level reference model.
// Latency: model effects of a word are compared two cycles after the TRNG presents it.
// Backpressure: consumer ready is held low, pulsed, driven high or randomised per phase.
module tb_trng_health_fifo;

  localparam int DEPTH         = 4;
  localparam int STARTUP_WORDS = 4;
  localparam int RCT_CUTOFF    = 3;
  localparam int APT_WINDOW    = 64;
  localparam int APT_LO        = 924;
  localparam int APT_HI        = 1124;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trng_request;
  logic        trng_ready;
  logic [31:0] trng_data;
  logic        rnd_valid;
  logic        rnd_ready;
  logic [31:0] rnd_data;
  logic        health_fail;
  logic [1:0]  fail_code;
  logic        startup_done;
  logic        fail_clear;

  always #5 clk = ~clk;

  trng_health_fifo #(
    .DEPTH(DEPTH), .STARTUP_WORDS(STARTUP_WORDS), .RCT_CUTOFF(RCT_CUTOFF),
    .APT_WINDOW(APT_WINDOW), .APT_LO(APT_LO), .APT_HI(APT_HI)
  ) dut (
    .clk(clk), .rst(rst),
    .trng_request(trng_request), .trng_ready(trng_ready), .trng_data(trng_data),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
    .health_fail(health_fail), .fail_code(fail_code), .startup_done(startup_done),
    .fail_clear(fail_clear)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: word-level history, window tallies and expected output order.
  logic [31:0] exp_q[$];
  logic [31:0] dir_q[$];
  logic [31:0] m_prev;
  bit          m_pv;
  int          m_run, m_sum, m_win, m_start;
  bit          m_alarm;
  logic [1:0]  m_code;

  logic [31:0] pend_word;
  int          pend_due   = -1;
  int          fill_len   = 32;
  int          fill_cnt   = -1;
  bit          fill_rand  = 1'b0;
  int          rdy_mode   = 0;
  bit          clr_req    = 1'b0;
  int          req_seen   = 0;
  int          words_sent = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [15:0] h;
    h = 16'($urandom);
    return {h, ~h};  // popcount is always 16, so random traffic never trips APT
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pv = 1'b0; m_run = 0; m_sum = 0; m_win = 0; m_start = 0;
    m_alarm = 1'b0; m_code = 2'b00; pend_due = -1;
  endtask

  task automatic model_word(input logic [31:0] w);
    bit rf, af;
    m_run = (m_pv && (w == m_prev)) ? m_run + 1 : 1;
    rf = (m_run >= RCT_CUTOFF);
    m_prev = w;
    m_pv = 1'b1;
    m_sum += $countones(w);
    m_win++;
    af = 1'b0;
    if (m_win == APT_WINDOW) begin
      af = (m_sum < APT_LO) || (m_sum > APT_HI);
      m_sum = 0;
      m_win = 0;
    end
    if (rf || af) begin
      m_alarm = 1'b1;
      m_code = {af, rf};
      exp_q.delete();
    end else if (m_start < STARTUP_WORDS) begin
      m_start++;
    end else begin
      exp_q.push_back(w);
    end
  endtask

  // One clock: observe #1 after the edge, update model/scoreboard, then drive the next inputs.
  task automatic step();
    bit          was_empty;
    bit          have;
    logic [31:0] want;
    @(posedge clk);
    #1;
    cyc++;
    if (trng_request) req_seen++;

    if (pend_due == cyc) begin
      pend_due = -1;
      was_empty = (exp_q.size() == 0);
      model_word(pend_word);
      check("health_fail", health_fail, m_alarm);
      check("fail_code", fail_code, m_code);
      check("startup_done", startup_done, m_start == STARTUP_WORDS);
      if (m_alarm) begin
        check("rnd_valid_on_alarm", rnd_valid, 1'b0);
      end else if (was_empty && exp_q.size() == 1) begin
        check("fwft_valid", rnd_valid, 1'b1);
        check("fwft_data", rnd_data, pend_word);
      end
    end

    case (rdy_mode)
      0: rnd_ready = 1'b0;
      1: rnd_ready = 1'b1;
      2: rnd_ready = 1'($urandom_range(0, 1));
      default: begin rnd_ready = 1'b1; rdy_mode = 0; end
    endcase
    if (rnd_valid && rnd_ready) begin
      have = (exp_q.size() != 0);
      want = 'x;
      if (have) want = exp_q.pop_front();
      n_assert++;
      assert (have && (rnd_data === want)) else begin
        n_fail++;
        $error("FAIL pop_data observed=%0h expected=%0h queued=%0d", rnd_data, want, have);
      end
    end

    if (!trng_request) begin
      trng_ready = 1'b0;
      fill_cnt = -1;
    end else if (!trng_ready) begin
      if (fill_cnt < 0) fill_cnt = fill_rand ? int'($urandom_range(0, 3)) : fill_len;
      if (fill_cnt == 0) begin
        trng_data = (dir_q.size() != 0) ? dir_q.pop_front() : rand_word();
        trng_ready = 1'b1;
        pend_word = trng_data;
        pend_due = cyc + 2;
        words_sent++;
        fill_cnt = -1;
      end else begin
        fill_cnt--;
      end
    end

    fail_clear = clr_req;
    if (clr_req && m_alarm) model_reset();
    clr_req = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_words(input string tag, input int n, input int maxc);
    int target;
    bit done;
    target = words_sent + n;
    done = 1'b0;
    for (int i = 0; i < maxc && !done; i++) begin
      step();
      done = (words_sent >= target) && (pend_due < 0);
    end
    n_assert++;
    assert (done) else begin
      n_fail++;
      $error("FAIL %s timeout observed=%0d words expected=%0d", tag, words_sent, target);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; trng_ready = 1'b0; rnd_ready = 1'b0; fail_clear = 1'b0; rdy_mode = 0;
    @(posedge clk);
    #1;
    cyc++;
    check("rst_request", trng_request, 1'b0);
    check("rst_rnd_valid", rnd_valid, 1'b0);
    check("rst_rnd_data", rnd_data, 32'h0);
    check("rst_health_fail", health_fail, 1'b0);
    check("rst_fail_code", fail_code, 2'b00);
    check("rst_startup_done", startup_done, 1'b0);
    rst = 1'b0;
    model_reset();
    fill_cnt = -1;
    step();
    check("first_request", trng_request, 1'b1);
  endtask

  initial begin
    trng_ready = 1'b0; trng_data = '0; rnd_ready = 1'b0; fail_clear = 1'b0;
    do_reset();

    // Startup discard with a slow 32-cycle TRNG fill and no consumer.
    fill_rand = 1'b0; fill_len = 32; rdy_mode = 0;
    run_words("startup", 5, 400);
    check("startup_done_after5", startup_done, 1'b1);
    check("word5_is_head", rnd_data, pend_word);

    // Fill the buffer, confirm requests stop, then free one slot.
    fill_rand = 1'b1;
    run_words("fill", 3, 200);
    req_seen = 0;
    wait_cycles(40);
    check("no_req_while_full", req_seen, 0);
    check("full_valid", rnd_valid, 1'b1);
    rdy_mode = 3;
    step();
    step();
    check("req_after_pop", trng_request, 1'b1);
    rdy_mode = 2;
    run_words("drain", 8, 400);

    // RCT: two repeats pass, three repeats alarm.
    rdy_mode = 1;
    dir_q.push_back(32'hA5A5_A5A5); dir_q.push_back(32'hA5A5_A5A5); dir_q.push_back(32'h1234_EDCB);
    run_words("rct_two", 3, 300);
    check("rct_two_no_alarm", health_fail, 1'b0);
    dir_q.push_back(32'hA5A5_A5A5); dir_q.push_back(32'hA5A5_A5A5); dir_q.push_back(32'hA5A5_A5A5);
    run_words("rct_three", 3, 300);
    check("rct_alarm", health_fail, 1'b1);
    check("rct_code", fail_code, 2'b01);
    req_seen = 0;
    wait_cycles(50);
    check("no_req_in_fail", req_seen, 0);
    check("no_valid_in_fail", rnd_valid, 1'b0);

    // Clear the alarm, restart with a fresh startup discard.
    clr_req = 1'b1;
    step();
    step();
    check("clr_health_fail", health_fail, 1'b0);
    check("clr_fail_code", fail_code, 2'b00);
    check("clr_startup_done", startup_done, 1'b0);
    run_words("restart", 6, 300);
    check("restart_startup_done", startup_done, 1'b1);
    clr_req = 1'b1;
    step();
    step();
    check("stray_clear_health", health_fail, 1'b0);
    check("stray_clear_startup", startup_done, 1'b1);
    run_words("after_stray", 2, 100);

    // APT: a balanced window passes, a low-ones window trips on its last word.
    for (int i = 0; i < 64; i++) dir_q.push_back((i % 2) != 0 ? 32'hFFFF_0000 : 32'h0000_FFFF);
    do_reset();
    rdy_mode = 1;
    run_words("apt_good", 63, 64 * 12);
    while (pend_due >= 0 || dir_q.size() != 0) step();
    check("apt_good_window", health_fail, 1'b0);
    for (int i = 0; i < 64; i++) dir_q.push_back((i % 2) != 0 ? 32'h0000_FF00 : 32'h0000_00FF);
    run_words("apt_bad63", 63, 63 * 12);
    check("apt_before_last", health_fail, 1'b0);
    run_words("apt_bad64", 1, 40);
    check("apt_alarm", health_fail, 1'b1);
    check("apt_code", fail_code, 2'b10);

    // Reset while a request is outstanding and two words are buffered.
    clr_req = 1'b1;
    rdy_mode = 0; fill_rand = 1'b0; fill_len = 10;
    step();
    run_words("prefill", 6, 200);
    for (int i = 0; i < 20 && !trng_request; i++) step();
    check("in_req_before_rst", trng_request, 1'b1);
    check("two_buffered_valid", rnd_valid, 1'b1);
    do_reset();
    rdy_mode = 1; fill_rand = 1'b1;
    run_words("post_rst", 6, 300);
    check("post_rst_startup_done", startup_done, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
